// File: rtl/cpu_sequencer_pkg.sv
// Shared processor definitions: ALU control codes, sequencer state encoding, defaults.
package cpu_sequencer_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'h0,
        ALU_SUB = 4'h1,
        ALU_AND = 4'h2,
        ALU_OR  = 4'h3,
        ALU_XOR = 4'h4,
        ALU_SHL = 4'h5,
        ALU_SHR = 4'h6,
        ALU_PASS = 4'h7
    } alu_ctrl_t;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_PAUSE     = 3'd5,
        S_HALT      = 3'd6
    } seq_state_t;

    localparam logic [3:0] HALT_OPCODE_DEF = 4'hF;

    function automatic logic is_busy_state(seq_state_t s);
        return (s == S_FETCH) || (s == S_DECODE) || (s == S_EXECUTE) ||
               (s == S_WRITEBACK) || (s == S_PAUSE);
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Control-unit <-> sequencer bundle: decoded instruction info in, datapath strobes out.
interface cpu_sequencer_if #(parameter int CNT_W = 16);
    import cpu_sequencer_pkg::*;

    logic             start;
    logic             step_mode;
    logic             step_req;
    logic             abort;
    logic [3:0]       opcode;
    logic [3:0]       pc;
    logic             dec_reg_we;
    logic             dec_mem_we;
    logic             pc_clr;
    logic             pc_inc;
    logic             ir_load;
    logic             reg_we;
    logic             mem_we;
    logic             busy;
    logic             halted;
    seq_state_t       state;
    logic [CNT_W-1:0] instr_count;

    modport master (
        output start, step_mode, step_req, abort, opcode, pc, dec_reg_we, dec_mem_we,
        input  pc_clr, pc_inc, ir_load, reg_we, mem_we, busy, halted, state, instr_count
    );

    modport slave (
        input  start, step_mode, step_req, abort, opcode, pc, dec_reg_we, dec_mem_we,
        output pc_clr, pc_inc, ir_load, reg_we, mem_we, busy, halted, state, instr_count
    );

endinterface

// File: rtl/cpu_sequencer_seq_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module seq_counter #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/cpu_sequencer.sv
// Instruction sequencer FSM: FETCH/DECODE/EXECUTE/WRITEBACK with single-step pause and halt.
// Strobes are decoded from the current state; abort and reset squash every strobe.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter logic [3:0] HALT_OPCODE  = HALT_OPCODE_DEF,
    parameter bit         HALT_ON_WRAP = 1'b1,
    parameter int         CNT_W        = 16
) (
    input  logic          clk,
    input  logic          reset,
    cpu_sequencer_if.slave bus
);

    seq_state_t r_state;
    seq_state_t w_next;
    logic       w_pc_clr;
    logic       w_pc_inc;
    logic       w_ir_load;
    logic       w_reg_we;
    logic       w_mem_we;
    logic       w_cnt_clr;
    logic       w_cnt_inc;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_pc_clr  = 1'b0;
        w_pc_inc  = 1'b0;
        w_ir_load = 1'b0;
        w_reg_we  = 1'b0;
        w_mem_we  = 1'b0;
        w_cnt_clr = 1'b0;
        w_cnt_inc = 1'b0;
        case (r_state)
            S_IDLE, S_HALT: begin
                if (bus.start) begin
                    w_next    = S_FETCH;
                    w_pc_clr  = 1'b1;
                    w_cnt_clr = 1'b1;
                end
            end
            S_FETCH: begin
                w_ir_load = 1'b1;
                w_next    = S_DECODE;
            end
            S_DECODE: begin
                w_next = (bus.opcode == HALT_OPCODE) ? S_HALT : S_EXECUTE;
            end
            S_EXECUTE: begin
                w_next = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                w_reg_we  = bus.dec_reg_we;
                w_mem_we  = bus.dec_mem_we;
                w_cnt_inc = 1'b1;
                // Halting at the top of program memory leaves the PC pointing at 15.
                if (HALT_ON_WRAP && (bus.pc == 4'hF)) begin
                    w_next = S_HALT;
                end else begin
                    w_pc_inc = 1'b1;
                    w_next   = bus.step_mode ? S_PAUSE : S_FETCH;
                end
            end
            S_PAUSE: begin
                if (bus.step_req) begin
                    w_next = S_FETCH;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        // Abort and reset cancel whatever this cycle would have committed.
        if (bus.abort || !reset) begin
            w_next    = S_IDLE;
            w_pc_clr  = 1'b0;
            w_pc_inc  = 1'b0;
            w_ir_load = 1'b0;
            w_reg_we  = 1'b0;
            w_mem_we  = 1'b0;
            w_cnt_clr = 1'b0;
            w_cnt_inc = 1'b0;
        end
    end

    seq_counter #(.W(CNT_W)) u_instr_cnt (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_clr   (w_cnt_clr),
        .i_inc   (w_cnt_inc),
        .o_count (bus.instr_count)
    );

    assign bus.pc_clr  = w_pc_clr;
    assign bus.pc_inc  = w_pc_inc;
    assign bus.ir_load = w_ir_load;
    assign bus.reg_we  = w_reg_we;
    assign bus.mem_we  = w_mem_we;
    assign bus.busy    = reset && is_busy_state(r_state);
    assign bus.halted  = reset && (r_state == S_HALT);
    assign bus.state   = r_state;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed scenarios plus a randomized run against a per-phase instruction model.
module tb_cpu_sequencer;
    import cpu_sequencer_pkg::*;

    localparam logic [6:0] O_PCCLR = 7'b1000000;
    localparam logic [6:0] O_PCINC = 7'b0100000;
    localparam logic [6:0] O_IRLD  = 7'b0010000;
    localparam logic [6:0] O_REGWE = 7'b0001000;
    localparam logic [6:0] O_MEMWE = 7'b0000100;
    localparam logic [6:0] O_BUSY  = 7'b0000010;
    localparam logic [6:0] O_HALT  = 7'b0000001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    cpu_sequencer_if #(.CNT_W(16)) sif ();
    cpu_sequencer_if #(.CNT_W(3))  sif2 ();

    cpu_sequencer #(.HALT_OPCODE(4'hF), .HALT_ON_WRAP(1'b1), .CNT_W(16)) u_dut (
        .clk(clk), .reset(rst_n), .bus(sif)
    );
    cpu_sequencer #(.HALT_OPCODE(4'hF), .HALT_ON_WRAP(1'b0), .CNT_W(3)) u_dut2 (
        .clk(clk), .reset(rst_n), .bus(sif2)
    );

    logic [6:0] obs, obs2;
    assign obs  = {sif.pc_clr, sif.pc_inc, sif.ir_load, sif.reg_we, sif.mem_we, sif.busy, sif.halted};
    assign obs2 = {sif2.pc_clr, sif2.pc_inc, sif2.ir_load, sif2.reg_we, sif2.mem_we, sif2.busy, sif2.halted};

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        sif.start = 0; sif.step_mode = 0; sif.step_req = 0; sif.abort = 0;
        sif.opcode = 4'h1; sif.pc = 4'h0; sif.dec_reg_we = 0; sif.dec_mem_we = 0;
        sif2.start = 0; sif2.step_mode = 0; sif2.step_req = 0; sif2.abort = 0;
        sif2.opcode = 4'h1; sif2.pc = 4'h0; sif2.dec_reg_we = 0; sif2.dec_mem_we = 0;
    endtask

    task automatic go_idle();
        sif.start = 0; sif2.start = 0;
        sif.abort = 1; sif2.abort = 1;
        cyc();
        clear_inputs();
    endtask

    // Issue start from IDLE/HALT and land in FETCH.
    task automatic launch();
        sif.start = 1;
        cyc();
        sif.start = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        cyc(); cyc(); settle();
        n_tests++; if (obs !== 7'b0) begin n_fail++; $display("FAIL reset_strobes: got %b want %b", obs, 7'b0); end
        n_tests++; if (sif.state !== S_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", sif.state, S_IDLE); end
        n_tests++; if (sif.instr_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", sif.instr_count); end
        rst_n = 1;
        cyc(); settle();
        n_tests++; if (obs !== 7'b0 || sif.state !== S_IDLE) begin n_fail++; $display("FAIL post_reset_idle: got %b/%0d want %b/%0d", obs, sif.state, 7'b0, S_IDLE); end
    endtask

    task automatic test_single_instr();
        sif.opcode = 4'h1; sif.dec_reg_we = 1; sif.pc = 4'h3;
        sif.start = 1; settle();
        n_tests++; if (obs !== O_PCCLR) begin n_fail++; $display("FAIL single_pcclr: got %b want %b", obs, O_PCCLR); end
        cyc(); sif.start = 0; settle();
        n_tests++; if (obs !== (O_IRLD | O_BUSY) || sif.state !== S_FETCH) begin n_fail++; $display("FAIL single_fetch: got %b/%0d want %b/%0d", obs, sif.state, O_IRLD | O_BUSY, S_FETCH); end
        cyc(); settle();
        n_tests++; if (obs !== O_BUSY || sif.state !== S_DECODE) begin n_fail++; $display("FAIL single_decode: got %b/%0d want %b/%0d", obs, sif.state, O_BUSY, S_DECODE); end
        cyc(); settle();
        n_tests++; if (obs !== O_BUSY || sif.state !== S_EXECUTE) begin n_fail++; $display("FAIL single_execute: got %b/%0d want %b/%0d", obs, sif.state, O_BUSY, S_EXECUTE); end
        cyc(); settle();
        n_tests++; if (obs !== (O_REGWE | O_PCINC | O_BUSY) || sif.instr_count !== 16'd0) begin n_fail++; $display("FAIL single_wb: got %b cnt %0d want %b cnt 0", obs, sif.instr_count, O_REGWE | O_PCINC | O_BUSY); end
        cyc(); settle();
        n_tests++; if (sif.instr_count !== 16'd1 || sif.state !== S_FETCH) begin n_fail++; $display("FAIL single_count: got %0d/%0d want 1/%0d", sif.instr_count, sif.state, S_FETCH); end
        go_idle();
    endtask

    task automatic test_halt_opcode();
        sif.opcode = 4'h1; sif.dec_reg_we = 1; sif.dec_mem_we = 1; sif.pc = 4'h2;
        launch();
        cyc(); cyc(); cyc(); cyc();
        sif.opcode = 4'hF;
        cyc(); cyc(); settle();
        n_tests++; if (sif.state !== S_HALT || obs !== O_HALT) begin n_fail++; $display("FAIL halt_opcode: got %0d/%b want %0d/%b", sif.state, obs, S_HALT, O_HALT); end
        n_tests++; if (sif.instr_count !== 16'd1) begin n_fail++; $display("FAIL halt_count: got %0d want 1", sif.instr_count); end
        sif.opcode = 4'h1; sif.start = 1; settle();
        n_tests++; if (obs !== (O_PCCLR | O_HALT)) begin n_fail++; $display("FAIL halt_restart_pcclr: got %b want %b", obs, O_PCCLR | O_HALT); end
        cyc(); sif.start = 0; settle();
        n_tests++; if (sif.state !== S_FETCH || sif.instr_count !== 16'd0) begin n_fail++; $display("FAIL halt_restart: got %0d cnt %0d want %0d cnt 0", sif.state, sif.instr_count, S_FETCH); end
        go_idle();
    endtask

    task automatic test_step_pause();
        sif.step_mode = 1; sif.opcode = 4'h2; sif.dec_mem_we = 1; sif.pc = 4'h5;
        launch();
        cyc(); cyc(); cyc(); settle();
        n_tests++; if (obs !== (O_MEMWE | O_PCINC | O_BUSY)) begin n_fail++; $display("FAIL step_wb: got %b want %b", obs, O_MEMWE | O_PCINC | O_BUSY); end
        sif.start = 1;
        for (int k = 0; k < 10; k++) begin
            cyc(); settle();
            n_tests++; if (sif.state !== S_PAUSE || obs !== O_BUSY) begin n_fail++; $display("FAIL step_hold%0d: got %0d/%b want %0d/%b", k, sif.state, obs, S_PAUSE, O_BUSY); end
        end
        sif.start = 0; sif.step_req = 1;
        cyc(); sif.step_req = 0; settle();
        n_tests++; if (sif.state !== S_FETCH || sif.instr_count !== 16'd1) begin n_fail++; $display("FAIL step_release: got %0d cnt %0d want %0d cnt 1", sif.state, sif.instr_count, S_FETCH); end
        go_idle();
    endtask

    task automatic test_wrap();
        sif.opcode = 4'h3; sif.dec_reg_we = 1; sif.pc = 4'hF;
        launch();
        cyc(); cyc(); cyc(); settle();
        n_tests++; if (obs !== (O_REGWE | O_BUSY)) begin n_fail++; $display("FAIL wrap_halt_wb: got %b want %b", obs, O_REGWE | O_BUSY); end
        cyc(); settle();
        n_tests++; if (sif.state !== S_HALT || sif.instr_count !== 16'd1) begin n_fail++; $display("FAIL wrap_halt_state: got %0d cnt %0d want %0d cnt 1", sif.state, sif.instr_count, S_HALT); end
        go_idle();
        sif2.opcode = 4'h3; sif2.pc = 4'hF;
        sif2.start = 1; cyc(); sif2.start = 0;
        cyc(); cyc(); cyc(); settle();
        n_tests++; if (obs2 !== (O_PCINC | O_BUSY)) begin n_fail++; $display("FAIL wrap_cont_wb: got %b want %b", obs2, O_PCINC | O_BUSY); end
        cyc(); settle();
        n_tests++; if (sif2.state !== S_FETCH) begin n_fail++; $display("FAIL wrap_cont_state: got %0d want %0d", sif2.state, S_FETCH); end
        go_idle();
    endtask

    task automatic test_saturate();
        sif2.opcode = 4'h4; sif2.pc = 4'h0;
        sif2.start = 1; cyc(); sif2.start = 0;
        for (int k = 1; k <= 10; k++) begin
            cyc(); cyc(); cyc(); cyc(); settle();
            n_tests++; if (sif2.instr_count !== 3'((k > 7) ? 7 : k)) begin n_fail++; $display("FAIL sat_count%0d: got %0d want %0d", k, sif2.instr_count, (k > 7) ? 7 : k); end
        end
        go_idle();
    endtask

    task automatic test_abort_wb();
        sif.opcode = 4'h5; sif.dec_mem_we = 1; sif.pc = 4'h1;
        launch();
        cyc(); cyc(); cyc(); cyc();
        cyc(); cyc(); cyc();
        sif.abort = 1; settle();
        n_tests++; if (obs !== O_BUSY) begin n_fail++; $display("FAIL abort_wb_strobes: got %b want %b", obs, O_BUSY); end
        cyc(); sif.abort = 0; settle();
        n_tests++; if (sif.state !== S_IDLE || sif.instr_count !== 16'd1) begin n_fail++; $display("FAIL abort_wb_next: got %0d cnt %0d want %0d cnt 1", sif.state, sif.instr_count, S_IDLE); end
        go_idle();
    endtask

    task automatic test_reset_mid();
        sif.opcode = 4'h6; sif.dec_reg_we = 1; sif.dec_mem_we = 1; sif.pc = 4'h4;
        launch();
        cyc(); cyc(); cyc(); cyc();
        cyc(); cyc();
        rst_n = 0; settle();
        n_tests++; if (obs !== 7'b0) begin n_fail++; $display("FAIL rst_exec_strobes: got %b want %b", obs, 7'b0); end
        cyc(); rst_n = 1; settle();
        n_tests++; if (sif.state !== S_IDLE || sif.instr_count !== 16'd0 || sif.busy !== 1'b0) begin n_fail++; $display("FAIL rst_exec_next: got %0d cnt %0d busy %b want %0d cnt 0 busy 0", sif.state, sif.instr_count, sif.busy, S_IDLE); end
        launch();
        cyc(); cyc(); cyc();
        rst_n = 0; settle();
        n_tests++; if (obs !== 7'b0) begin n_fail++; $display("FAIL rst_wb_strobes: got %b want %b", obs, 7'b0); end
        cyc(); rst_n = 1; settle();
        n_tests++; if (sif.state !== S_IDLE || sif.instr_count !== 16'd0) begin n_fail++; $display("FAIL rst_wb_next: got %0d cnt %0d want %0d cnt 0", sif.state, sif.instr_count, S_IDLE); end
        go_idle();
    endtask

    // Each instruction is four phases: fetch, decode, execute, writeback.
    task automatic test_random();
        int         cnt;
        logic [3:0] op, p;
        logic       rw, mw, stop;
        logic [6:0] exp;
        sif.start = 1; settle();
        n_tests++; if (obs !== O_PCCLR) begin n_fail++; $display("FAIL rnd_start: got %b want %b", obs, O_PCCLR); end
        cyc(); sif.start = 0;
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            op = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            p  = 4'($urandom_range(0, 15));
            rw = 1'($urandom); mw = 1'($urandom);
            sif.opcode = op; sif.pc = p; sif.dec_reg_we = rw; sif.dec_mem_we = mw;
            settle();
            n_tests++; if (obs !== (O_IRLD | O_BUSY) || sif.instr_count !== 16'(cnt)) begin n_fail++; $display("FAIL rnd_fetch%0d: got %b cnt %0d want %b cnt %0d", i, obs, sif.instr_count, O_IRLD | O_BUSY, cnt); end
            cyc(); settle();
            n_tests++; if (obs !== O_BUSY) begin n_fail++; $display("FAIL rnd_decode%0d: got %b want %b", i, obs, O_BUSY); end
            cyc();
            stop = (op == 4'hF);
            if (!stop) begin
                settle();
                n_tests++; if (obs !== O_BUSY) begin n_fail++; $display("FAIL rnd_exec%0d: got %b want %b", i, obs, O_BUSY); end
                cyc(); settle();
                exp = O_BUSY | (rw ? O_REGWE : 7'b0) | (mw ? O_MEMWE : 7'b0) | ((p != 4'hF) ? O_PCINC : 7'b0);
                n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL rnd_wb%0d: got %b want %b", i, obs, exp); end
                cnt = cnt + 1;
                cyc();
                stop = (p == 4'hF);
            end
            if (stop) begin
                settle();
                n_tests++; if (obs !== O_HALT || sif.instr_count !== 16'(cnt)) begin n_fail++; $display("FAIL rnd_halt%0d: got %b cnt %0d want %b cnt %0d", i, obs, sif.instr_count, O_HALT, cnt); end
                sif.start = 1;
                cyc(); sif.start = 0;
                cnt = 0;
            end
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_single_instr();
        test_halt_opcode();
        test_step_pause();
        test_wrap();
        test_saturate();
        test_abort_wb();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter HALT_OPCODE, default 4'hF: opcode that ends execution when decoded.
REQ-002 Parameter HALT_ON_WRAP, default 1: when 1, halt instead of wrapping the PC from 15 to 0.
REQ-003 Parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 start  in  1  run request; sampled in IDLE and HALT.
REQ-007 step_mode  in  1  when 1, pause after every retired instruction.
REQ-008 step_req  in  1  releases one instruction from PAUSE.
REQ-009 abort  in  1  forces return to IDLE from any state.
REQ-010 opcode  in  4  decoded opcode from the control unit.
REQ-011 pc  in  4  current program counter value.
REQ-012 dec_reg_we / dec_mem_we  in  1 each  write enables decoded by the control unit.
REQ-013 pc_clr  out  1  synchronous clear strobe to the PC.
REQ-014 pc_inc  out  1  PC advance strobe.
REQ-015 ir_load  out  1  instruction-register capture strobe.
REQ-016 reg_we / mem_we  out  1 each  gated write enables to the datapath.
REQ-017 busy  out  1  high in FETCH, DECODE, EXECUTE, WRITEBACK and PAUSE.
REQ-018 halted  out  1  high in HALT only.
REQ-019 state  out  3  current state encoding, for debug.
REQ-020 instr_count  out  CNT_W  number of instructions retired since the last run start.

Function
REQ-021 States SHALL be IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, PAUSE and HALT.
REQ-022 IDLE: when start=1, go to FETCH; assert pc_clr in that same cycle; clear instr_count.
REQ-023 FETCH: assert ir_load; go to DECODE.
REQ-024 DECODE: if opcode==HALT_OPCODE go to HALT (nothing retires); otherwise go to EXECUTE.
REQ-025 EXECUTE: no strobes; go to WRITEBACK. This cycle lets the ALU result settle.
REQ-026 WRITEBACK: reg_we=dec_reg_we; mem_we=dec_mem_we; instr_count increments.
REQ-027 WRITEBACK exit, first matching rule applies:
  - if HALT_ON_WRAP=1 and pc==4'hF: go to HALT with pc_inc=0.
  - else if step_mode=1: pulse pc_inc and go to PAUSE.
  - else: pulse pc_inc and go to FETCH.
REQ-028 PAUSE: if step_req=1 go to FETCH; start is ignored.
REQ-029 HALT: halted=1. If start=1: go to FETCH, assert pc_clr and clear instr_count.
REQ-030 HALT_ON_WRAP=0 and pc==4'hF in WRITEBACK: pc_inc is asserted; the PC wraps to 0 and execution continues.
REQ-031 Latency with step_mode=0 is exactly 4 cycles per instruction (FETCH to WRITEBACK).
REQ-032 abort=1 has priority over every transition: the next state is IDLE. If abort is asserted in WRITEBACK, reg_we, mem_we and pc_inc are forced to 0 and instr_count does not increment.
REQ-033 instr_count saturates at all-ones; it never wraps.
REQ-034 All strobe outputs are single-cycle and decoded from the current state (plus start/abort where stated); no output is 1 outside the states named above.

Reset
REQ-035 reset=0 at a clock edge forces state=IDLE and instr_count=0. This holds mid-instruction, including in WRITEBACK, where writes are suppressed in that cycle.
REQ-036 During and after reset, all strobes, busy and halted are 0; pc_clr is 0 until a start is sampled.

Structure
REQ-037 The state enumeration (3-bit encoding) and the default HALT_OPCODE constant live in the shared processor package, next to the ALU control codes.
REQ-038 One sub-module, seq_counter (saturating, clearable counter), implements instr_count. The FSM stays in cpu_sequencer.

Verification
REQ-039 Reset, then start=1 for 1 cycle with step_mode=0 and non-halt opcode 4'h1 with dec_reg_we=1. Required: pc_clr in the start cycle; then ir_load, then reg_we and pc_inc 3 cycles later. instr_count=1 after 4 cycles.
REQ-040 Opcode 4'hF presented in DECODE. Required: HALT next cycle, halted=1, no reg_we/mem_we, instr_count unchanged.
REQ-041 step_mode=1. Required: PAUSE after WRITEBACK, held for 10 cycles without step_req. A step_req pulse then gives FETCH on the next cycle.
REQ-042 pc=4'hF in WRITEBACK with HALT_ON_WRAP=1. Required: pc_inc=0 and HALT. Repeat with HALT_ON_WRAP=0: pc_inc=1 and FETCH.
REQ-043 abort asserted in WRITEBACK with dec_mem_we=1. Required: mem_we=0, pc_inc=0, IDLE next cycle, instr_count unchanged.
REQ-044 reset=0 asserted in EXECUTE. Required: IDLE next cycle, instr_count=0, busy=0.
